// File: rtl/apple_placer_pkg.sv
// rtl/apple_placer_pkg.sv - shared snake playfield constants, coordinate widths and placer states
package apple_placer_pkg;

  localparam int GRID_W     = 40;
  localparam int GRID_H     = 30;
  localparam int WALL_MIN   = 1;
  localparam int WALL_MAX_X = 38;
  localparam int WALL_MAX_Y = 28;

  localparam int X_W = 6;
  localparam int Y_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_t;

endpackage

// File: rtl/apple_placer_lfsr16.sv
// rtl/apple_placer_lfsr16.sv - 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1
module apple_placer_lfsr16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  // Shift left, feedback into bit 0; a non-zero seed never reaches the all-zero lockup state
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= seed;
    end else if (en) begin
      q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    end
  end

endmodule

// File: rtl/apple_placer.sv
// rtl/apple_placer.sv - places the apple on a legal random cell after each eat event
module apple_placer
  import apple_placer_pkg::*;
#(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_TRIES = 16,
  parameter bit          FREE_RUN  = 1'b1,
  parameter int          INIT_X    = 24,
  parameter int          INIT_Y    = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           restart,
  input  logic           inc_len,
  input  logic [5:0]     head_x,
  input  logic [5:0]     head_y,
  output logic [X_W-1:0] apple_x,
  output logic [Y_W-1:0] apple_y,
  output logic           apple_valid,
  output logic [7:0]     draws
);

  localparam logic [X_W-1:0] INIT_X_C = X_W'(INIT_X);
  localparam logic [Y_W-1:0] INIT_Y_C = Y_W'(INIT_Y);
  localparam logic [X_W-1:0] ALT_X_C  = X_W'(INIT_X + 4);
  localparam logic [7:0]     LAST_TRY = 8'(MAX_TRIES - 1);

  state_t         state_q, state_d;
  logic [7:0]     try_cnt_q, try_cnt_d;
  logic [X_W-1:0] apple_x_d;
  logic [Y_W-1:0] apple_y_d;
  logic           apple_valid_d;
  logic [7:0]     draws_d;

  logic [15:0]    lfsr_q;
  logic           lfsr_en;
  logic [X_W-1:0] cand_x;
  logic [Y_W-1:0] cand_y;
  logic           in_walls, on_head, on_apple, cand_legal;
  logic           init_free;
  logic           unused_lfsr_bits;

  assign lfsr_en = FREE_RUN || (state_q == DRAW);

  apple_placer_lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (lfsr_en),
    .seed  (SEED),
    .q     (lfsr_q)
  );

  assign cand_x           = lfsr_q[5:0];
  assign cand_y           = lfsr_q[12:8];
  assign unused_lfsr_bits = ^{lfsr_q[15:13], lfsr_q[7:6]};

  // Candidate legality; a head with row bit 5 set is off the board and cannot collide
  always_comb begin
    in_walls   = (cand_x >= X_W'(WALL_MIN)) && (cand_x <= X_W'(WALL_MAX_X)) &&
                 (cand_y >= Y_W'(WALL_MIN)) && (cand_y <= Y_W'(WALL_MAX_Y));
    on_head    = (cand_x == head_x) && !head_y[5] && (cand_y == head_y[4:0]);
    on_apple   = (cand_x == apple_x) && (cand_y == apple_y);
    cand_legal = in_walls && !on_head && !on_apple;
    init_free  = !((INIT_X_C == head_x) && !head_y[5] && (INIT_Y_C == head_y[4:0])) &&
                 !((INIT_X_C == apple_x) && (INIT_Y_C == apple_y));
  end

  // Next-state and next-output logic for the IDLE/DRAW placer
  always_comb begin
    state_d       = state_q;
    try_cnt_d     = try_cnt_q;
    apple_x_d     = apple_x;
    apple_y_d     = apple_y;
    apple_valid_d = apple_valid;
    draws_d       = draws;
    case (state_q)
      IDLE: begin
        apple_valid_d = 1'b1;
        if (inc_len) begin
          state_d       = DRAW;
          apple_valid_d = 1'b0;
          try_cnt_d     = 8'd0;
          draws_d       = 8'd0;
        end
      end
      DRAW: begin
        draws_d = (draws == 8'hFF) ? 8'hFF : draws + 8'd1;
        if (cand_legal) begin
          apple_x_d     = cand_x;
          apple_y_d     = cand_y;
          apple_valid_d = 1'b1;
          state_d       = IDLE;
        end else if (try_cnt_q == LAST_TRY) begin
          apple_x_d     = init_free ? INIT_X_C : ALT_X_C;
          apple_y_d     = INIT_Y_C;
          apple_valid_d = 1'b1;
          state_d       = IDLE;
        end else begin
          try_cnt_d = try_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered state and outputs; restart restores the reset values but leaves the LFSR running
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      state_q     <= IDLE;
      try_cnt_q   <= 8'd0;
      apple_x     <= INIT_X_C;
      apple_y     <= INIT_Y_C;
      apple_valid <= 1'b1;
      draws       <= 8'd0;
    end else begin
      state_q     <= state_d;
      try_cnt_q   <= try_cnt_d;
      apple_x     <= apple_x_d;
      apple_y     <= apple_y_d;
      apple_valid <= apple_valid_d;
      draws       <= draws_d;
    end
  end

endmodule

// File: tb/tb_apple_placer.sv
// tb/tb_apple_placer.sv - directed and soak bench for apple_placer
module tb_apple_placer;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       det_restart = 1'b0, det_inc = 1'b0;
  logic [5:0] det_hx = 6'd0, det_hy = 6'd0;
  logic [5:0] det_ax;
  logic [4:0] det_ay;
  logic       det_valid;
  logic [7:0] det_draws;

  logic       fb_restart = 1'b0, fb_inc = 1'b0;
  logic [5:0] fb_hx = 6'd0, fb_hy = 6'd0;
  logic [5:0] fb_ax;
  logic [4:0] fb_ay;
  logic       fb_valid;
  logic [7:0] fb_draws;

  logic       sk_restart = 1'b0, sk_inc = 1'b0;
  logic [5:0] sk_hx = 6'd0, sk_hy = 6'd0;
  logic [5:0] sk_ax;
  logic [4:0] sk_ay;
  logic       sk_valid;
  logic [7:0] sk_draws;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apple_placer #(.SEED(16'h0A05), .MAX_TRIES(16), .FREE_RUN(1'b0)) u_det (
    .clk(clk), .reset(reset), .restart(det_restart), .inc_len(det_inc),
    .head_x(det_hx), .head_y(det_hy), .apple_x(det_ax), .apple_y(det_ay),
    .apple_valid(det_valid), .draws(det_draws)
  );

  apple_placer #(.SEED(16'h003F), .MAX_TRIES(1), .FREE_RUN(1'b0)) u_fb (
    .clk(clk), .reset(reset), .restart(fb_restart), .inc_len(fb_inc),
    .head_x(fb_hx), .head_y(fb_hy), .apple_x(fb_ax), .apple_y(fb_ay),
    .apple_valid(fb_valid), .draws(fb_draws)
  );

  apple_placer #(.SEED(16'hACE1), .MAX_TRIES(16), .FREE_RUN(1'b1)) u_soak (
    .clk(clk), .reset(reset), .restart(sk_restart), .inc_len(sk_inc),
    .head_x(sk_hx), .head_y(sk_hy), .apple_x(sk_ax), .apple_y(sk_ay),
    .apple_valid(sk_valid), .draws(sk_draws)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_det(input string tag, input int x, input int y, input int v, input int d);
    check({tag, "_x"}, int'(det_ax), x);
    check({tag, "_y"}, int'(det_ay), y);
    check({tag, "_valid"}, int'(det_valid), v);
    check({tag, "_draws"}, int'(det_draws), d);
  endtask

  task automatic check_fb(input string tag, input int x, input int y, input int v, input int d);
    check({tag, "_x"}, int'(fb_ax), x);
    check({tag, "_y"}, int'(fb_ay), y);
    check({tag, "_valid"}, int'(fb_valid), v);
    check({tag, "_draws"}, int'(fb_draws), d);
  endtask

  function automatic bit legal_pos(input int x, input int y, input int hx, input int hy,
                                   input int px, input int py);
    return (x >= 1) && (x <= 38) && (y >= 1) && (y <= 28) &&
           !((x == hx) && (y == hy)) && !((x == px) && (y == py));
  endfunction

  initial begin
    int px, py, hx, hy, gap, fbx;
    bit ok;

    // Reset held for two cycles
    step();
    step();
    reset = 1'b0;
    check_det("reset_det", 24, 10, 1, 0);
    check_fb("reset_fb", 24, 10, 1, 0);

    // Direct hit: seed 0A05 gives candidate (5,10) on the first draw
    det_inc = 1'b1;
    step();
    det_inc = 1'b0;
    check("hit_valid_low", int'(det_valid), 0);
    step();
    check_det("hit", 5, 10, 1, 1);

    // Second placement from LFSR 140A -> candidate (10,20)
    det_inc = 1'b1;
    step();
    det_inc = 1'b0;
    step();
    check_det("second", 10, 20, 1, 1);

    // restart after a placement returns to the initial apple
    det_restart = 1'b1;
    step();
    det_restart = 1'b0;
    check_det("restart", 24, 10, 1, 0);

    // Placement from LFSR 2814 -> (20,8), then restart coincident with inc_len
    det_inc = 1'b1;
    step();
    det_inc = 1'b0;
    step();
    check_det("third", 20, 8, 1, 1);
    det_inc = 1'b1;
    det_restart = 1'b1;
    step();
    det_inc = 1'b0;
    det_restart = 1'b0;
    check_det("restart_vs_inc", 24, 10, 1, 0);
    step();
    check_det("restart_stays_idle", 24, 10, 1, 0);

    // Reseed; head on the first candidate forces a second draw, inc_len inside DRAW ignored
    reset = 1'b1;
    step();
    reset = 1'b0;
    det_hx = 6'd5;
    det_hy = 6'd10;
    det_inc = 1'b1;
    step();
    check("rej_valid_low0", int'(det_valid), 0);
    step();
    det_inc = 1'b0;
    check("rej_valid_low1", int'(det_valid), 0);
    step();
    check_det("head_reject", 10, 20, 1, 2);
    step();
    check_det("reject_single_place", 10, 20, 1, 2);

    // Fallback, one try: old apple (24,10) blocks the initial cell -> (28,10)
    fb_inc = 1'b1;
    step();
    fb_inc = 1'b0;
    check("fb1_valid_low", int'(fb_valid), 0);
    step();
    check_fb("fb1", 28, 10, 1, 1);
    // Old apple (28,10), head (0,0) -> initial cell is free
    fb_inc = 1'b1;
    step();
    fb_inc = 1'b0;
    step();
    check_fb("fb2", 24, 10, 1, 1);
    // Head on the initial cell -> alternate cell
    fb_hx = 6'd24;
    fb_hy = 6'd10;
    fb_inc = 1'b1;
    step();
    fb_inc = 1'b0;
    step();
    check_fb("fb3", 28, 10, 1, 1);

    // Soak with a free-running LFSR and random head positions
    for (int i = 0; i < 10000; i++) begin
      hx = int'($urandom_range(0, 39));
      hy = int'($urandom_range(0, 29));
      sk_hx = 6'(hx);
      sk_hy = 6'(hy);
      px = int'(sk_ax);
      py = int'(sk_ay);
      if ($urandom_range(0, 3) == 0) step();
      sk_inc = 1'b1;
      step();
      sk_inc = 1'b0;
      gap = 1;
      while (!sk_valid && gap < 40) begin
        step();
        gap++;
      end
      ok = (gap >= 2) && (gap <= 17);
      check("soak_gap_ok", int'(ok), 1);
      check("soak_draws", int'(sk_draws), gap - 1);
      fbx = (!((hx == 24) && (hy == 10)) && !((px == 24) && (py == 10))) ? 24 : 28;
      ok = legal_pos(int'(sk_ax), int'(sk_ay), hx, hy, px, py) ||
           ((sk_draws == 8'd16) && (int'(sk_ax) == fbx) && (sk_ay == 5'd10));
      check("soak_legal", int'(ok), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apple_placer.md
Name: apple_placer

Overview:
- Generates and holds the apple cell position for the snake game on the 40x30 cell playfield (640x480 VGA, 16-px cells).
- Feeds apple_x/apple_y to the eat-detection and VGA display stages, and consumes their inc_len "apple eaten" pulse.
- On each eat event, draws pseudo-random candidates from an LFSR until one is legal: inside the walls, not on the snake head, and not on the previous apple.
- A bounded retry count plus a fixed fallback guarantee a finite placement latency.

Parameters:
SEED, 16'hACE1, LFSR reset value (must be non-zero).
MAX_TRIES, 16, rejected draws allowed before using the fallback (1..255).
FREE_RUN, 1, 1 = LFSR advances every cycle (player timing adds entropy); 0 = advances only in DRAW (deterministic for test).
INIT_X, 24, apple x after reset/restart.
INIT_Y, 10, apple y after reset/restart.

Ports:
clk  in  1  system clock; single clock domain.
reset  in  1  synchronous, active-high reset.
restart  in  1  one-cycle pulse; new game, same effect as reset except the LFSR is not reseeded.
inc_len  in  1  one-cycle pulse; apple eaten at current position.
head_x  in  6  snake head cell column.
head_y  in  6  snake head cell row (only [4:0] compared; [5] must be 0 for a match).
apple_x  out  6  apple cell column.
apple_y  out  5  apple cell row.
apple_valid  out  1  1 = apple_x/apple_y hold a placed apple; 0 = placement in progress (consumers ignore the position).
draws  out  8  number of candidates examined in the last placement, saturating at 255.

Behaviour:
- Clocking: all state updates on posedge clk. reset (synchronous, active-high) has highest priority.
- Reset values: apple_x=INIT_X, apple_y=INIT_Y, apple_valid=1, draws=0, state=IDLE, lfsr=SEED, try_cnt=0.
- restart, second priority: same values as reset, but the lfsr keeps its current value. restart wins over a coincident inc_len and aborts an in-progress DRAW.
- LFSR: 16-bit Fibonacci, shift left, new bit0 = b15^b13^b12^b10 (x^16+x^14+x^13+x^11+1). It never reaches zero.
  - Advances every cycle if FREE_RUN=1.
  - Advances only in cycles where state=DRAW if FREE_RUN=0.
- Candidate: combinational, from the current lfsr value. cand_x = lfsr[5:0], cand_y = lfsr[12:8].
- Candidate is legal iff all of:
  - 1<=cand_x<=38 and 1<=cand_y<=28 (cells 0, 39 and row 0, 29 are wall);
  - (cand_x,cand_y) != (head_x,head_y);
  - (cand_x,cand_y) != (apple_x,apple_y).
- State machine IDLE / DRAW:
  - IDLE: apple_valid=1. inc_len=1 -> DRAW, apple_valid<=0, try_cnt<=0, draws<=0. Otherwise hold.
  - DRAW: each cycle evaluate the candidate and increment draws (saturating).
    - Legal: apple_x/apple_y <= candidate, apple_valid<=1 -> IDLE.
    - Illegal and try_cnt==MAX_TRIES-1: fallback placement, apple_valid<=1 -> IDLE.
    - Illegal otherwise: try_cnt++, stay in DRAW.
  - inc_len while in DRAW is ignored; the apple is not valid, so it cannot be eaten.
- Fallback: (INIT_X,INIT_Y) if that differs from head and from the old apple; else (INIT_X+4,INIT_Y).
- Latency: apple_valid falls the cycle after inc_len. It rises no earlier than 2 cycles after inc_len and no later than MAX_TRIES+1 cycles after.
- head_x/head_y are sampled live each DRAW cycle; head movement during DRAW is honoured.
- Outputs are registered only; no combinational path from input to output.

Decomposition:
- Shared snake package holds:
  - GRID_W=40, GRID_H=30, WALL_MIN=1, WALL_MAX_X=38, WALL_MAX_Y=28;
  - state enum {IDLE, DRAW};
  - coordinate widths (X_W=6, Y_W=5).
- One sub-module is natural: lfsr16 (clk, reset, en, seed, q). It is reusable for future random features.
- Legality check stays inline as combinational logic.

Test Plan:
- Reset: assert reset 2 cycles -> apple=(24,10), apple_valid=1, draws=0. Assert restart after a placement -> apple back to (24,10), valid=1.
- Direct hit, FREE_RUN=0, SEED=16'h0A05, head=(0,0): pulse inc_len -> valid=0 next cycle; next cycle apple=(5,10), valid=1, draws=1.
- Head rejection: same seed, head=(5,10) -> first candidate rejected, apple != (5,10), draws>=2; result meets all legality rules.
- Fallback: FREE_RUN=0, MAX_TRIES=1, SEED=16'h003F (x=63 illegal) -> apple=(24,10) if old apple/head differ, else (28,10); valid returns 2 cycles after inc_len.
- Ignore during DRAW, and restart priority: inc_len pulses inside DRAW are ignored, with exactly one placement and draws unaffected. restart coincident with inc_len -> stays IDLE at (24,10).
- Soak, FREE_RUN=1: 10,000 random inc_len pulses with random head -> every placement legal; valid gap <= MAX_TRIES+1 cycles; never equals the previous apple.
